// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants for the fetch-stage branch predictor: opcodes, default widths
// and the 2-bit bimodal counter type with its saturating update rule.
package branch_predictor_bht_pkg;

    localparam int BP_ADDRESS_SIZE     = 64;
    localparam int BP_INSTRUCTION_SIZE = 32;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_counter_t;

    function automatic bht_counter_t bht_next(input bht_counter_t c, input logic taken);
        bht_counter_t n;
        n = c;
        if (taken && (c != BHT_ST)) begin
            n = bht_counter_t'(c + 2'd1);
        end else if (!taken && (c != BHT_SNT)) begin
            n = bht_counter_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored. Used by branch_predictor_bht only under BP_RAS_EN.
module bp_return_stack
    import branch_predictor_bht_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BP_ADDRESS_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_inc;
    logic [PTR_W-1:0] w_dec;

    assign w_inc   = (r_top == PTR_W'(DEPTH - 1)) ? '0 : r_top + PTR_W'(1);
    assign w_dec   = (r_top == '0) ? PTR_W'(DEPTH - 1) : r_top - PTR_W'(1);
    assign o_top   = r_stack[r_top];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push && !i_pop) begin
            r_top   <= w_inc;
            r_count <= o_full ? r_count : r_count + (PTR_W + 1)'(1);
        end else if (i_pop && !i_push && !o_empty) begin
            r_top   <= w_dec;
            r_count <= r_count - (PTR_W + 1)'(1);
        end
    end

    // Simultaneous push and pop replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_stack[i_pop ? r_top : w_inc] <= i_push_data;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Fetch-stage next-PC predictor: JAL always redirects, conditional branches follow a
// 2-bit bimodal table trained from execute. Optional return stack under BP_RAS_EN.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int ADDRESS_SIZE     = BP_ADDRESS_SIZE,
    parameter int INSTRUCTION_SIZE = BP_INSTRUCTION_SIZE,
    parameter int BHT_ENTRIES      = 64,
    parameter int RAS_DEPTH        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDRESS_SIZE-1:0]     pc,
    input  logic [INSTRUCTION_SIZE-1:0] instruction,
    input  logic                        update_valid,
    input  logic [ADDRESS_SIZE-1:0]     update_pc,
    input  logic                        update_taken,
    output logic [ADDRESS_SIZE-1:0]     next_pc,
    output logic                        overwrite_pc
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_counter_t            r_bht [BHT_ENTRIES];
    logic [6:0]              w_opcode;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_uidx;
    bht_counter_t            w_ctr;
    logic [ADDRESS_SIZE-1:0] w_imm_j;
    logic [ADDRESS_SIZE-1:0] w_imm_b;
    logic [ADDRESS_SIZE-1:0] w_next_pc;
    logic                    w_overwrite;
    logic                    w_unused_upc;

    assign w_opcode     = instruction[6:0];
    assign w_idx        = pc[IDX_W+1:2];
    assign w_uidx       = update_pc[IDX_W+1:2];
    assign w_ctr        = r_bht[w_idx];
    assign w_unused_upc = ^{update_pc[ADDRESS_SIZE-1:IDX_W+2], update_pc[1:0]};

    assign w_imm_j = {{(ADDRESS_SIZE-21){instruction[31]}}, instruction[31],
                      instruction[19:12], instruction[20], instruction[30:21], 1'b0};
    assign w_imm_b = {{(ADDRESS_SIZE-13){instruction[31]}}, instruction[31],
                      instruction[7], instruction[30:25], instruction[11:8], 1'b0};

`ifdef BP_RAS_EN
    logic [4:0]              w_rd;
    logic [4:0]              w_rs1;
    logic                    w_rd_link;
    logic                    w_rs1_link;
    logic                    w_ras_push;
    logic                    w_ras_pop;
    logic [ADDRESS_SIZE-1:0] w_ras_top;
    logic                    w_ras_empty;
    logic                    w_ras_full_unused;

    assign w_rd       = instruction[11:7];
    assign w_rs1      = instruction[19:15];
    assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_ras_push = ((w_opcode == OPCODE_JAL) || (w_opcode == OPCODE_JALR)) && w_rd_link;
    assign w_ras_pop  = (w_opcode == OPCODE_JALR) && (w_rd == 5'd0) && w_rs1_link && !w_ras_empty;

    bp_return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDRESS_SIZE)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_data (pc + ADDRESS_SIZE'(4)),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full_unused)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
`endif

    always_comb begin
        w_next_pc   = pc + ADDRESS_SIZE'(4);
        w_overwrite = 1'b0;
        if (!reset) begin
            case (w_opcode)
                OPCODE_JAL: begin
                    w_overwrite = 1'b1;
                    w_next_pc   = pc + w_imm_j;
                end
                OPCODE_BRANCH: begin
                    if ((w_ctr == BHT_WT) || (w_ctr == BHT_ST)) begin
                        w_overwrite = 1'b1;
                        w_next_pc   = pc + w_imm_b;
                    end
                end
`ifdef BP_RAS_EN
                OPCODE_JALR: begin
                    if (w_ras_pop) begin
                        w_overwrite = 1'b1;
                        w_next_pc   = w_ras_top;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign next_pc      = w_next_pc;
    assign overwrite_pc = w_overwrite;

    // Lookups read the registered table, so a same-cycle update is seen only next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= BHT_WNT;
            end
        end else if (update_valid) begin
            r_bht[w_uidx] <= bht_next(r_bht[w_uidx], update_taken);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus randomized
// traffic against a behavioural model (BHT as integer counters, RAS as a queue).
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        update_valid;
    logic [63:0] update_pc;
    logic        update_taken;
    logic [63:0] next_pc;
    logic        overwrite_pc;

    int          checks   = 0;
    int          failures = 0;
    int          bht [64];
    logic [63:0] ras_q [$];

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ADDRESS_SIZE     (64),
        .INSTRUCTION_SIZE (32),
        .BHT_ENTRIES      (64),
        .RAS_DEPTH        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .next_pc      (next_pc),
        .overwrite_pc (overwrite_pc)
    );

    function automatic int idx(input logic [63:0] a);
        return int'((a / 64'd4) % 64'd64);
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [12:0] off);
        return {off[12], off[10:5], 5'd0, 5'd0, 3'd0, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'd0, rd, 7'b1100111};
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) bht[i] = 1;
        ras_q.delete();
    endfunction

    // Drive one cycle from a negedge, check outputs mid-low-phase, advance the model at posedge.
    task automatic step(input string tag, input logic [63:0] p, input logic [31:0] ins,
                        input logic uv, input logic [63:0] upc, input logic ut,
                        input logic exp_ow, input logic [63:0] exp_npc);
        pc = p; instruction = ins; update_valid = uv; update_pc = upc; update_taken = ut;
        #2;
        check1({tag, "/overwrite"}, overwrite_pc, exp_ow);
        check64({tag, "/next_pc"}, next_pc, exp_npc);
        @(posedge clk);
        if (uv) begin
            if (ut) bht[idx(upc)] = (bht[idx(upc)] == 3) ? 3 : bht[idx(upc)] + 1;
            else    bht[idx(upc)] = (bht[idx(upc)] == 0) ? 0 : bht[idx(upc)] - 1;
        end
        @(negedge clk);
        update_valid = 1'b0;
    endtask

    task automatic br_step(input string tag, input logic [63:0] p, input logic [12:0] off,
                           input logic uv, input logic [63:0] upc, input logic ut);
        logic taken;
        taken = (bht[idx(p)] >= 2);
        step(tag, p, enc_br(off), uv, upc, ut, taken,
             taken ? p + {{51{off[12]}}, off} : p + 64'd4);
    endtask

    task automatic jal_step(input string tag, input logic [63:0] p, input logic [20:0] off,
                            input logic [4:0] rd, input logic uv, input logic [63:0] upc,
                            input logic ut);
        step(tag, p, enc_jal(off, rd), uv, upc, ut, 1'b1, p + {{43{off[20]}}, off});
        if (rd == 5'd1 || rd == 5'd5) begin
            ras_q.push_back(p + 64'd4);
            if (ras_q.size() > 4) void'(ras_q.pop_front());
        end
    endtask

    task automatic ret_step(input string tag, input logic [63:0] p);
        if (ras_q.size() > 0) begin
            step(tag, p, 32'h0000_8067, 1'b0, 64'd0, 1'b0, 1'b1, ras_q[$]);
            void'(ras_q.pop_back());
        end else begin
            step(tag, p, 32'h0000_8067, 1'b0, 64'd0, 1'b0, 1'b0, p + 64'd4);
        end
    endtask

    initial begin
        logic [63:0] rpc, rupc;
        logic [31:0] rins, rnd;
        logic [20:0] roff21;
        logic [12:0] roff13;
        logic        ruv, rut;
        int          kind;

        reset = 1'b1; pc = 64'h1000; instruction = 32'h0000_0063;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
        model_reset();
        #3;
        check1("reset_hold/overwrite", overwrite_pc, 1'b0);
        check64("reset_hold/next_pc", next_pc, 64'h1004);
        @(negedge clk);
        reset = 1'b0;

        step("after_reset_beq", 64'h1000, 32'h0000_0063, 1'b0, 64'd0, 1'b0, 1'b0, 64'h1004);
        step("jal_fwd", 64'h1000, 32'h0080_006F, 1'b0, 64'd0, 1'b0, 1'b1, 64'h1008);
        step("jal_back", 64'h1000, 32'hFF9F_F06F, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0FF8);

        // Training: the second update coincides with a lookup that must see the old counter.
        step("train1", 64'h1000, 32'h0000_0863, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h1004);
        step("train2_same_cycle", 64'h1000, 32'h0000_0863, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1010);
        step("beq_taken", 64'h1000, 32'h0000_0863, 1'b0, 64'd0, 1'b0, 1'b1, 64'h1010);
        for (int i = 0; i < 4; i++) br_step("train_sat", 64'h1000, 13'd16, 1'b1, 64'h1000, 1'b1);
        step("nt1", 64'h0, 32'h0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h4);
        step("after_nt1", 64'h1000, 32'h0000_0863, 1'b1, 64'h1000, 1'b0, 1'b1, 64'h1010);
        step("after_nt2", 64'h1000, 32'h0000_0863, 1'b0, 64'd0, 1'b0, 1'b0, 64'h1004);

        step("alias_train", 64'h0, 32'h0, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h4);
        step("alias_lookup", 64'h1100, 32'h0000_0863, 1'b0, 64'd0, 1'b0, 1'b1, 64'h1110);

        // Asynchronous reset in the middle of a cycle, with an update in flight.
        br_step("pre_reset_train", 64'h1000, 13'd16, 1'b1, 64'h1000, 1'b1);
        pc = 64'h1000; instruction = 32'h0000_0863;
        update_valid = 1'b1; update_pc = 64'h1000; update_taken = 1'b1;
        #2;
        check1("pre_reset/overwrite", overwrite_pc, 1'b1);
        reset = 1'b1;
        #1;
        check1("in_reset/overwrite", overwrite_pc, 1'b0);
        check64("in_reset/next_pc", next_pc, 64'h1004);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; update_valid = 1'b0;
        #2;
        check1("post_reset/overwrite", overwrite_pc, 1'b0);
        @(negedge clk);
        step("post_reset_one_up", 64'h0, 32'h0, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h4);
        step("post_reset_is_wnt", 64'h1000, 32'h0000_0863, 1'b0, 64'd0, 1'b0, 1'b1, 64'h1010);

`ifdef BP_RAS_EN
        step("ras_jal_x1", 64'h2000, 32'h1000_00EF, 1'b0, 64'd0, 1'b0, 1'b1, 64'h2100);
        ras_q.push_back(64'h2004);
        step("ras_ret", 64'h3000, 32'h0000_8067, 1'b0, 64'd0, 1'b0, 1'b1, 64'h2004);
        void'(ras_q.pop_back());
        step("ras_ret_empty", 64'h3000, 32'h0000_8067, 1'b0, 64'd0, 1'b0, 1'b0, 64'h3004);
        for (int k = 0; k < 5; k++)
            jal_step("ras_fill", 64'h4000 + 64'(k * 16), 21'h40, 5'd1, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 5; k++) ret_step("ras_drain", 64'h5000);
        step("ras_jalr_push", 64'h6000, enc_jalr(5'd5, 5'd1), 1'b0, 64'd0, 1'b0, 1'b0, 64'h6004);
        ras_q.push_back(64'h6004);
        ret_step("ras_ret_after_jalr", 64'h7000);
`else
        step("jalr_no_ras", 64'h3000, 32'h0000_8067, 1'b0, 64'd0, 1'b0, 1'b0, 64'h3004);
`endif

        for (int n = 0; n < 400; n++) begin
            rpc = {$urandom(), $urandom()} & ~64'h3;
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FF00 | (rpc & 64'hFC);
            ruv  = 1'($urandom_range(0, 1));
            rut  = 1'($urandom_range(0, 1));
            rupc = ($urandom_range(0, 1) == 1) ? rpc : {$urandom(), $urandom()};
            rnd  = $urandom();
            roff13 = {rnd[12:1], 1'b0};
            roff21 = {rnd[20:1], 1'b0};
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: br_step("rand_branch", rpc, roff13, ruv, rupc, rut);
                2: jal_step("rand_jal", rpc, roff21, 5'd0, ruv, rupc, rut);
                3: step("rand_jalr", rpc, enc_jalr(5'd2, 5'd2), ruv, rupc, rut, 1'b0, rpc + 64'd4);
                4: step("rand_bubble", rpc, 32'h0, ruv, rupc, rut, 1'b0, rpc + 64'd4);
                default: begin
                    rins = (rnd & 32'hFFFF_FF80) | 32'h13;
                    step("rand_alu", rpc, rins, ruv, rupc, rut, 1'b0, rpc + 64'd4);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
